rc4_phase_sequencer: RTL



---
 rtl/rc4_pkg.sv | 24 ++
 rtl/rc4_phase_sequencer_if.sv | 41 ++++
 rtl/rc4_phase_sequencer_s_mem_port_mux.sv | 36 +++
 rtl/rc4_phase_sequencer.sv | 120 ++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rc4_pkg: shared state encoding and phase constants for the RC4 sequencer.
// Rev 1.0
// ---------------------------------------------------------------------------
package rc4_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    RUN    = 3'd2,
    DONE   = 3'd3,
    ERR    = 3'd4
  } state_t;

  localparam int PH_W    = 2;
  localparam int PH_INIT = 0;
  localparam int PH_KSA  = 1;
  localparam int PH_PRGA = 2;

  localparam int DEFAULT_TIMEOUT_CYCLES = 4096;

endpackage
`default_nettype wire

// File: rtl/rc4_phase_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rc4_phase_sequencer_if: start/done handshake, engine and S-memory signals.
// Rev 1.0
// ---------------------------------------------------------------------------
interface rc4_phase_sequencer_if
  import rc4_pkg::*;
#(
  parameter int NUM_PHASES = 3
) ();

  logic                    start;
  logic [NUM_PHASES-1:0]   phase_start;
  logic [NUM_PHASES-1:0]   phase_finish;
  logic [8*NUM_PHASES-1:0] ph_addr;
  logic [8*NUM_PHASES-1:0] ph_data;
  logic [NUM_PHASES-1:0]   ph_wren;
  logic [7:0]              s_mem_address;
  logic [7:0]              s_mem_data;
  logic                    s_mem_wren;
  logic [PH_W-1:0]         active_phase;
  logic                    busy;
  logic                    done;
  logic                    error;

  // Environment side: issues start, hosts the engines and the S memory.
  modport master (
    output start, phase_finish, ph_addr, ph_data, ph_wren,
    input  phase_start, s_mem_address, s_mem_data, s_mem_wren,
    input  active_phase, busy, done, error
  );

  // Sequencer side.
  modport slave (
    input  start, phase_finish, ph_addr, ph_data, ph_wren,
    output phase_start, s_mem_address, s_mem_data, s_mem_wren,
    output active_phase, busy, done, error
  );

endinterface
`default_nettype wire

// File: rtl/rc4_phase_sequencer_s_mem_port_mux.sv
`default_nettype none
// ---------------------------------------------------------------------------
// s_mem_port_mux: routes the granted engine's slice onto the S memory port.
// Rev 1.0
// ---------------------------------------------------------------------------
module s_mem_port_mux
  import rc4_pkg::*;
#(
  parameter int NUM_PHASES = 3
) (
  input  logic                    grant_valid,
  input  logic [PH_W-1:0]         grant,
  input  logic [8*NUM_PHASES-1:0] ph_addr,
  input  logic [8*NUM_PHASES-1:0] ph_data,
  input  logic [NUM_PHASES-1:0]   ph_wren,
  output logic [7:0]              s_mem_address,
  output logic [7:0]              s_mem_data,
  output logic                    s_mem_wren
);

  // Idle port parks at zero so a stray wren from any engine cannot write S.
  always_comb begin
    s_mem_address = '0;
    s_mem_data    = '0;
    s_mem_wren    = 1'b0;
    for (int k = 0; k < NUM_PHASES; k++) begin
      if (grant_valid && (grant == PH_W'(k))) begin
        s_mem_address = ph_addr[8*k +: 8];
        s_mem_data    = ph_data[8*k +: 8];
        s_mem_wren    = ph_wren[k];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rc4_phase_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rc4_phase_sequencer: runs S-init, KSA and PRGA engines in turn with a
// per-phase watchdog and owns the shared S memory port. Rev 1.0
// ---------------------------------------------------------------------------
module rc4_phase_sequencer
  import rc4_pkg::*;
#(
  parameter int NUM_PHASES     = 3,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CNT_W          = 13
) (
  input  logic                   inclk,
  input  logic                   reset_n,
  rc4_phase_sequencer_if.slave   bus
);

  state_t                state;
  logic [NUM_PHASES-1:0] fin_prev;
  logic [CNT_W-1:0]      watchdog;
  logic                  grant_valid;
  logic [PH_W-1:0]       active_phase;
  logic [NUM_PHASES-1:0] phase_start;
  logic                  busy;
  logic                  done;
  logic                  error;

  logic finish_evt;
  logic timeout_hit;
  logic last_phase;

  // Only a fresh rising edge on the granted engine's flag counts.
  assign finish_evt  = bus.phase_finish[active_phase] & ~fin_prev[active_phase];
  assign timeout_hit = (watchdog == CNT_W'(TIMEOUT_CYCLES - 1));
  assign last_phase  = (active_phase == PH_W'(NUM_PHASES - 1));

  always_ff @(posedge inclk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      fin_prev     <= '0;
      watchdog     <= '0;
      grant_valid  <= 1'b0;
      active_phase <= '0;
      phase_start  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      fin_prev    <= bus.phase_finish;
      phase_start <= '0;
      done        <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state        <= LAUNCH;
            active_phase <= PH_W'(PH_INIT);
            error        <= 1'b0;
            busy         <= 1'b1;
          end
        end
        LAUNCH: begin
          phase_start <= NUM_PHASES'(1) << active_phase;
          grant_valid <= 1'b1;
          watchdog    <= '0;
          state       <= RUN;
        end
        RUN: begin
          watchdog <= watchdog + CNT_W'(1);
          // A finish landing on the timeout cycle still completes the phase.
          if (finish_evt) begin
            if (last_phase) begin
              state       <= DONE;
              busy        <= 1'b0;
              grant_valid <= 1'b0;
            end else begin
              active_phase <= active_phase + PH_W'(1);
              state        <= LAUNCH;
            end
          end else if (timeout_hit) begin
            state       <= ERR;
            busy        <= 1'b0;
            grant_valid <= 1'b0;
          end
        end
        DONE: begin
          done        <= 1'b1;
          grant_valid <= 1'b0;
          state       <= IDLE;
        end
        ERR: begin
          error       <= 1'b1;
          grant_valid <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.phase_start  = phase_start;
  assign bus.active_phase = active_phase;
  assign bus.busy         = busy;
  assign bus.done         = done;
  assign bus.error        = error;

  s_mem_port_mux #(
    .NUM_PHASES (NUM_PHASES)
  ) u_mux (
    .grant_valid   (grant_valid),
    .grant         (active_phase),
    .ph_addr       (bus.ph_addr),
    .ph_data       (bus.ph_data),
    .ph_wren       (bus.ph_wren),
    .s_mem_address (bus.s_mem_address),
    .s_mem_data    (bus.s_mem_data),
    .s_mem_wren    (bus.s_mem_wren)
  );

endmodule
`default_nettype wire
